// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM states, sizing.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div_op(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide; purely combinational.
// Accumulator layout: multiply {partial_hi, multiplier}, divide {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    // A successful subtract always leaves a value below the divisor, so WIDTH bits suffice.
    rem_sub = rem_sh[WIDTH-1:0] - opnd;
    q_bit   = 1'b0;
    acc_nxt = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      q_bit   = (rem_sh >= {1'b0, opnd});
      acc_nxt = {(q_bit ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: WIDTH iterations on magnitudes, sign fix, one-cycle HI/LO write.
// Stalls the pipeline from issue through FIX; a flush abandons the op with no write.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             stall_req,
  output logic             done,
  output logic             we_hilo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t             state, state_nxt;
  op_t                op_q;
  logic               sign_a, sign_b, dz_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_prev, lo_prev;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] mul_res;
  logic               q_bit;

  op_t              op_in;
  logic             in_signed, in_sa, in_sb, in_dz;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_in     = op_t'(op);
  assign in_signed = is_signed_op(op_in);
  assign in_sa     = in_signed & src_a[WIDTH-1];
  assign in_sb     = in_signed & src_b[WIDTH-1];
  assign mag_a     = in_sa ? -src_a : src_a;
  assign mag_b     = in_sb ? -src_b : src_b;
  assign in_dz     = is_div_op(op_in) && (src_b == '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_op(op_q)),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && !cancel) state_nxt = in_dz ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (cancel)                      state_nxt = ST_IDLE;
        else if (cnt == CW'(WIDTH - 1)) state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = cancel ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      stall_req = ((state == ST_IDLE) && start && !cancel) ||
                  (state == ST_CALC) || (state == ST_FIX);
      done      = (state == ST_DONE) && !cancel;
    end
    we_hilo  = done;
    div_zero = done & dz_q;
  end

  always_comb begin
    mul_res = (sign_a ^ sign_b) ? -acc : acc;
    fix_hi  = mul_res[2*WIDTH-1:WIDTH];
    fix_lo  = mul_res[WIDTH-1:0];
    if (is_div_op(op_q)) begin
      fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_MULT;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dz_q    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_prev <= '0;
      lo_prev <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !cancel) begin
            op_q   <= op_in;
            sign_a <= in_sa;
            sign_b <= in_sb;
            cnt    <= '0;
            dz_q   <= in_dz;
            opnd   <= is_div_op(op_in) ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, (is_div_op(op_in) ? mag_a : mag_b)};
            if (in_dz) begin
              hi_prev <= hi_q;
              lo_prev <= lo_q;
              hi_q    <= src_a;
              lo_q    <= '1;
            end
          end
        end
        ST_CALC: begin
          if (!cancel) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            hi_prev <= hi_q;
            lo_prev <= lo_q;
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
          end
        end
        ST_DONE: begin
          // A flush during the write cycle rolls HI/LO back to the last committed result.
          if (cancel) begin
            hi_q <= hi_prev;
            lo_q <= lo_prev;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized scoreboard bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        cancel = 1'b0;
  logic        stall_req, done, we_hilo, div_zero;
  logic [31:0] hi_out, lo_out;

  int   checks = 0;
  int   passed = 0;
  int   n_writes = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .stall_req(stall_req), .done(done), .we_hilo(we_hilo),
    .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic exp_t ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    case (o)
      2'd0: begin sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
      2'd1: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.dz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
          sp = sa / sb; e.lo = sp[31:0];
          sp = sa % sb; e.hi = sp[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (we_hilo) begin
      exp_t e;
      n_writes++;
      chk("done_eq_we", {63'd0, done}, 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("hi", {32'd0, hi_out}, {32'd0, e.hi});
        chk("lo", {32'd0, lo_out}, {32'd0, e.lo});
        chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1 chk("stall_issue", {63'd0, stall_req}, 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int   k;
    logic got, stall_gap;
    exp_q.push_back(ref_model(o, a, b));
    issue(o, a, b);
    k = 0; got = 1'b0; stall_gap = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (done) got = 1'b1;
      else if (!stall_req) stall_gap = 1'b1;
    end
    chk("latency", 64'(k), (o[1] && b == 32'd0) ? 64'd1 : 64'd34);
    chk("stall_busy", {63'd0, stall_gap}, 64'd0);
    chk("stall_in_done", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] hi_save, lo_save;
    int          w_save;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", {32'd0, hi_out}, 64'd0);
    chk("rst_lo", {32'd0, lo_out}, 64'd0);
    chk("rst_flags", {60'd0, done, we_hilo, div_zero, stall_req}, 64'd0);

    run_op(2'd0, 32'hFFFF_FFFD, 32'd5);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd3, 32'd100, 32'd0);
    run_op(2'd2, 32'h1234_5678, 32'd0);

    // Flush mid-calculation: sampled at the tenth edge after issue.
    hi_save = hi_out; lo_save = lo_out; w_save = n_writes;
    issue(2'd0, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle_stall", {63'd0, stall_req}, 64'd0);
    repeat (40) @(negedge clk);
    chk("cancel_no_write", 64'(n_writes), 64'(w_save));
    chk("cancel_hi_kept", {32'd0, hi_out}, {32'd0, hi_save});
    chk("cancel_lo_kept", {32'd0, lo_out}, {32'd0, lo_save});
    run_op(2'd3, 32'd9, 32'd4);

    // Reset mid-calculation.
    w_save = n_writes;
    issue(2'd0, 32'h0000_0777, 32'h0000_0333);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_hi", {32'd0, hi_out}, 64'd0);
    chk("rstmid_lo", {32'd0, lo_out}, 64'd0);
    chk("rstmid_flags", {60'd0, done, we_hilo, div_zero, stall_req}, 64'd0);
    repeat (40) @(negedge clk);
    chk("rstmid_no_write", 64'(n_writes), 64'(w_save));

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(o, a, b);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
